sram_queue_512x64: RTL and testbench

SRAM_QUEUE_512X64 -- requirements
Module: sram_queue_512x64

---
 rtl/sram_queue_512x64.sv | 112 +++++++++++
 tb/tb_sram_queue_512x64.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_queue_512x64.sv
// 512x64 queue backed by an external single-port-per-direction SRAM, with a
// two-entry output buffer that hides the one-cycle SRAM read latency.
module sram_queue_512x64 #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [DATA_W-1:0] mem_R0_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   sram_cnt_q, sram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [1:0][DATA_W-1:0] buf_q, buf_d;

  logic              enq_fire;
  logic              deq_fire;
  logic              rd_issue;
  logic [ADDR_W:0]   count_raw;
  logic [2:0]        occ_after_deq;

  assign count_raw = sram_cnt_q
                   + {{ADDR_W{1'b0}}, inflight_q}
                   + {{(ADDR_W-1){1'b0}}, buf_cnt_q};

  // Every externally visible handshake/count is forced quiet while in reset,
  // including the cycle in which reset first drops before the clearing edge.
  assign enq_ready = reset & (count_raw != FULL_CNT);
  assign deq_valid = reset & (buf_cnt_q != 2'd0);
  assign deq_bits  = deq_valid ? buf_q[0] : '0;
  assign count     = reset ? count_raw : '0;

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;

  // Slots that will be committed in the output buffer once the pending read
  // lands, net of an entry leaving this cycle.
  assign occ_after_deq = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, deq_fire};
  assign rd_issue      = reset & (sram_cnt_q != '0) & (occ_after_deq < 3'd2);

  assign mem_W0_en   = enq_fire;
  assign mem_W0_addr = wr_ptr_q;
  assign mem_W0_data = enq_bits;
  assign mem_R0_en   = rd_issue;
  assign mem_R0_addr = rd_ptr_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(ADDR_W-1){1'b0}}, enq_fire};
    rd_ptr_d   = rd_ptr_q + {{(ADDR_W-1){1'b0}}, rd_issue};
    sram_cnt_d = sram_cnt_q + {{ADDR_W{1'b0}}, enq_fire} - {{ADDR_W{1'b0}}, rd_issue};
    inflight_d = rd_issue;
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;

    case ({inflight_q, deq_fire})
      2'b10: begin
        buf_d[buf_cnt_q[0]] = mem_R0_data;
        buf_cnt_d           = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf_d[0]  = buf_q[1];
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf_d[0] = mem_R0_data;
        end else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = mem_R0_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_sram_queue_512x64.sv
// Directed bench for sram_queue_512x64 with a behavioural 512x64 SRAM attached.
module tb_sram_queue_512x64;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [63:0] enq_bits;
  logic        deq_valid;
  logic        deq_ready;
  logic [63:0] deq_bits;
  logic [9:0]  count;
  logic [8:0]  mem_W0_addr;
  logic        mem_W0_en;
  logic [63:0] mem_W0_data;
  logic [8:0]  mem_R0_addr;
  logic        mem_R0_en;
  logic [63:0] mem_R0_data;

  logic [63:0] sram [0:511];

  int total = 0;
  int bad   = 0;

  sram_queue_512x64 dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data),
    .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_W0_en) sram[mem_W0_addr] <= mem_W0_data;
    if (mem_R0_en) mem_R0_data <= sram[mem_R0_addr];
    else           mem_R0_data <= 'x;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drain(input int first, input int last);
    int e = first;
    int n = 0;
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    while (e <= last && n < 3000) begin
      settle;
      if (deq_valid) begin
        chk("drain_data", deq_bits, 64'(e));
        e++;
      end
      step;
      n++;
    end
    chk("drain_done", 64'(e), 64'(last + 1));
    deq_ready = 1'b0;
  endtask

  logic [63:0] sb[$];
  int          bufm, infl, deqf, stalled_prev, wcnt, n;
  logic [63:0] held, exp_v;

  initial begin
    reset = 1'b0; enq_valid = 1'b1; enq_bits = 64'h1234; deq_ready = 1'b1;
    #1;
    repeat (3) step;
    settle;
    chk("rst_enq_ready", enq_ready, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_w0_en", mem_W0_en, 0);
    chk("rst_r0_en", mem_R0_en, 0);
    chk("rst_deq_bits", deq_bits, 0);
    step;

    // single entry latency
    reset = 1'b1; deq_ready = 1'b0;
    enq_valid = 1'b1; enq_bits = 64'hDEADBEEF_00000001;
    settle;
    chk("one_w0_en", mem_W0_en, 1);
    chk("one_w0_addr", mem_W0_addr, 0);
    chk("one_w0_data", mem_W0_data, 64'hDEADBEEF_00000001);
    step;
    enq_valid = 1'b0;
    settle;
    chk("one_r0_en", mem_R0_en, 1);
    chk("one_r0_addr", mem_R0_addr, 0);
    chk("one_cnt_t1", count, 1);
    chk("one_dv_t1", deq_valid, 0);
    step; settle;
    chk("one_dv_t2", deq_valid, 0);
    step; settle;
    chk("one_dv_t3", deq_valid, 1);
    chk("one_bits_t3", deq_bits, 64'hDEADBEEF_00000001);
    chk("one_cnt_t3", count, 1);
    deq_ready = 1'b1;
    step;
    deq_ready = 1'b0;
    settle;
    chk("one_empty_cnt", count, 0);
    chk("one_empty_dv", deq_valid, 0);
    chk("one_empty_bits", deq_bits, 0);
    step;

    // fill to 512
    for (int i = 0; i < 512; i++) begin
      enq_valid = 1'b1; enq_bits = 64'(i);
      settle;
      chk("fill_rdy", enq_ready, 1);
      step;
    end
    enq_bits = 64'd999;
    settle;
    chk("full_cnt", count, 512);
    chk("full_rdy", enq_ready, 0);
    chk("full_w0_en", mem_W0_en, 0);
    step; settle;
    chk("full_cnt_hold", count, 512);

    // full with enq and deq together: only the deq happens
    deq_ready = 1'b1;
    settle;
    chk("fulldeq_rdy", enq_ready, 0);
    chk("fulldeq_dv", deq_valid, 1);
    chk("fulldeq_bits", deq_bits, 0);
    step;
    enq_valid = 1'b0;
    settle;
    chk("fulldeq_cnt", count, 511);
    chk("fulldeq_rdy_next", enq_ready, 1);
    drain(1, 511);
    settle;
    chk("fill_empty", count, 0);
    step;

    // streaming
    for (int i = 0; i < 2000; i++) begin
      enq_valid = 1'b1; enq_bits = 64'(i); deq_ready = 1'b1;
      settle;
      chk("stream_rdy", enq_ready, 1);
      chk("stream_cnt_le3", 64'(count <= 10'd3), 1);
      chk("stream_dv", deq_valid, 64'(i >= 3));
      if (i >= 3) chk("stream_data", deq_bits, 64'(i - 3));
      step;
    end
    drain(1997, 1999);
    settle;
    chk("stream_empty", count, 0);
    step;

    // back-pressure with scoreboard
    bufm = 0; infl = 0; stalled_prev = 0; wcnt = 0; held = '0;
    for (int i = 0; i < 400; i++) begin
      enq_valid = ($urandom_range(0, 9) < 8);
      enq_bits  = {32'hB0B0_0000, 32'(wcnt)};
      deq_ready = ($urandom_range(0, 9) < 3);
      settle;
      deqf = int'(deq_valid & deq_ready);
      chk("bp_rden_gap", 64'(mem_R0_en && (bufm + infl - deqf) >= 2), 0);
      chk("bp_buf_le2", 64'(bufm <= 2), 1);
      chk("bp_dv", deq_valid, 64'(bufm > 0));
      if (stalled_prev != 0 && deq_valid) chk("bp_hold", deq_bits, held);
      if (deqf != 0) begin
        exp_v = (sb.size() > 0) ? sb.pop_front() : 64'hBAD;
        chk("bp_data", deq_bits, exp_v);
      end
      if (enq_valid && enq_ready) begin
        sb.push_back(enq_bits);
        wcnt++;
      end
      stalled_prev = int'(deq_valid & ~deq_ready);
      held = deq_bits;
      bufm = bufm + infl - deqf;
      infl = int'(mem_R0_en);
      step;
    end
    enq_valid = 1'b0; deq_ready = 1'b1; n = 0;
    while (sb.size() > 0 && n < 2000) begin
      settle;
      if (deq_valid) begin
        exp_v = sb.pop_front();
        chk("bp_drain", deq_bits, exp_v);
      end
      step;
      n++;
    end
    chk("bp_sb_empty", 64'(sb.size()), 0);
    deq_ready = 1'b0;
    settle;
    chk("bp_cnt_zero", count, 0);
    step;

    // reset mid-stream with a read in flight
    for (int i = 0; i < 100; i++) begin
      enq_valid = 1'b1; enq_bits = 64'(1000 + i);
      step;
    end
    enq_valid = 1'b1; enq_bits = 64'd2000; deq_ready = 1'b1;
    settle;
    chk("mid_cnt_pre", count, 100);
    step;
    enq_valid = 1'b0; deq_ready = 1'b0;
    settle;
    chk("mid_cnt_inflight", count, 100);
    reset = 1'b0;
    settle;
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_dv", deq_valid, 0);
    chk("mid_rst_rdy", enq_ready, 0);
    step; step; settle;
    chk("mid_rst_cnt2", count, 0);
    chk("mid_rst_r0", mem_R0_en, 0);
    step;
    reset = 1'b1; enq_valid = 1'b1; enq_bits = 64'h5;
    settle;
    chk("post_rst_rdy", enq_ready, 1);
    step;
    enq_valid = 1'b0;
    n = 1;
    settle;
    while (!deq_valid && n < 10) begin
      step;
      settle;
      n++;
    end
    chk("post_rst_lat", 64'(n), 3);
    chk("post_rst_bits", deq_bits, 64'h5);
    chk("post_rst_cnt", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
